// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results (alu_*) and valid/ready load results (mem_*) onto the registered register-file write port (rf_*), queues losing loads, flags rs/rt hazards (rs/rt_pending)
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  output logic        rs_pending_o,
  output logic        rt_pending_o,
  output logic        rf_regWrite_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o
);
  logic [4:0] q_rd_q [DEPTH];
  logic [31:0] q_data_q [DEPTH];
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic rf_we_q, rf_we_d;
  logic [4:0] rf_rd_q, rf_rd_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic full, deq, alu_win, byp, enq, win;
  logic [4:0] win_rd;
  logic [31:0] win_data;
  logic [DEPTH-1:0] rs_hit, rt_hit;
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [AW-1:0] off;
    logic live;
    assign off = AW'(i) - rd_ptr_q;
    assign live = {1'b0, off} < count_q;
    assign rs_hit[i] = live && q_rd_q[i] == rs_i;
    assign rt_hit[i] = live && q_rd_q[i] == rt_i;
  end
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    alu_ready_o = !reset_i && !full;
    mem_ready_o = !reset_i && !full;
    deq = full || (!alu_valid_i && count_q != '0);
    alu_win = !full && alu_valid_i;
    byp = !full && !alu_valid_i && count_q == '0 && mem_valid_i;
    enq = mem_valid_i && mem_ready_o && !byp;
    win = deq || alu_win || byp;
    win_rd = deq ? q_rd_q[rd_ptr_q] : alu_win ? alu_rd_i : mem_rd_i;
    win_data = deq ? q_data_q[rd_ptr_q] : alu_win ? alu_data_i : mem_data_i;
    count_d = count_q + (AW+1)'(enq) - (AW+1)'(deq);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    wr_ptr_d = wr_ptr_q + AW'(enq);
    rf_we_d = win && win_rd != '0;
    rf_rd_d = win ? win_rd : rf_rd_q;
    rf_data_d = win ? win_data : rf_data_q;
    rs_pending_o = !reset_i && rs_i != '0 && ((rf_we_q && rs_i == rf_rd_q) || |rs_hit);
    rt_pending_o = !reset_i && rt_i != '0 && ((rf_we_q && rt_i == rf_rd_q) || |rt_hit);
  end
  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_rd_q[wr_ptr_q] <= mem_rd_i;
      q_data_q[wr_ptr_q] <= mem_data_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_data_q <= '0;
    end else begin
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end
  assign rf_regWrite_o = rf_we_q;
  assign rf_rd_o = rf_rd_q;
  assign rf_data_o = rf_data_q;
endmodule
